// File: rtl/muldiv_ctrl.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO result registers.
// One operand bit is retired per RUN cycle; results commit on the last RUN edge.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for start; mthi/mtlo may write HI/LO
// S_RUN  | 32 shift-add or restoring-divide iterations, busy=1
// S_DONE | one-cycle done pulse, HI/LO hold the new result
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] BusA,
  input  logic [31:0] BusB,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic        is_div_q;
  logic        neg_q;
  logic        rneg_q;
  logic        dz_q;
  logic [31:0] b_q;
  logic [31:0] a_raw_q;
  logic [63:0] p_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;

  // Signed ops work on magnitudes; signs are re-applied when the result commits.
  logic        is_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  assign is_signed = ~op[0];
  assign a_mag     = (is_signed && BusA[31]) ? (32'd0 - BusA) : BusA;
  assign b_mag     = (is_signed && BusB[31]) ? (32'd0 - BusB) : BusB;

  logic [32:0] mul_add;
  logic [63:0] mul_step;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] div_step;
  logic [63:0] p_d;
  logic [63:0] mul_res;
  logic [31:0] hi_d;
  logic [31:0] lo_d;

  // p_q holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_add   = {1'b0, p_q[63:32]} + {1'b0, b_q};
    mul_step  = p_q[0] ? {mul_add, p_q[31:1]} : {1'b0, p_q[63:1]};
    div_shift = {p_q[63:32], p_q[31]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_diff  = div_shift[31:0] - b_q;
    div_step  = div_ge ? {div_diff, p_q[30:0], 1'b1}
                       : {div_shift[31:0], p_q[30:0], 1'b0};
    p_d       = is_div_q ? div_step : mul_step;
    mul_res   = neg_q ? (64'd0 - p_d) : p_d;
    hi_d      = mul_res[63:32];
    lo_d      = mul_res[31:0];
    if (is_div_q) begin
      if (dz_q) begin
        hi_d = a_raw_q;
        lo_d = 32'hFFFF_FFFF;
      end else begin
        hi_d = rneg_q ? (32'd0 - p_d[63:32]) : p_d[63:32];
        lo_d = neg_q  ? (32'd0 - p_d[31:0])  : p_d[31:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      b_q      <= 32'd0;
      a_raw_q  <= 32'd0;
      p_q      <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
            cnt_q    <= 5'd31;
            is_div_q <= op[1];
            neg_q    <= is_signed & (BusA[31] ^ BusB[31]);
            rneg_q   <= is_signed & BusA[31];
            dz_q     <= op[1] & (BusB == 32'd0);
            a_raw_q  <= BusA;
            b_q      <= b_mag;
            p_q      <= {32'd0, a_mag};
          end else begin
            if (mthi) hi_q <= BusA;
            if (mtlo) lo_q <= BusA;
          end
        end
        S_RUN: begin
          p_q   <= p_d;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: cycle-exact busy/done timing and HI/LO results
// against hand-computed values.
module tb_muldiv_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] BusA;
  logic [31:0] BusB;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  muldiv_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .BusA  (BusA),
    .BusB  (BusB),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .busy  (busy),
    .done  (done),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // mode: 0 plain, 1 disturb inputs mid-run, 2 reset in cycle 10, 3 mthi/mtlo with start
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int mode);
    bit quiet;
    @(negedge clk);
    start = 1'b1; op = o; BusA = a; BusB = b;
    if (mode == 3) begin mthi = 1'b1; mtlo = 1'b1; end
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = ~o; BusA = ~a; BusB = b + 32'd3;
    for (int k = 0; k < 34; k++) begin
      if (k > 0) @(negedge clk);
      if (mode == 2 && k == 11) begin
        chk($sformatf("%s_abort_busy", nm), 32'(busy), 32'd0);
        chk($sformatf("%s_abort_done", nm), 32'(done), 32'd0);
        chk($sformatf("%s_abort_hi", nm), HI, 32'd0);
        chk($sformatf("%s_abort_lo", nm), LO, 32'd0);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        quiet = 1'b1;
        repeat (40) begin
          @(negedge clk);
          if (done || busy) quiet = 1'b0;
        end
        chk($sformatf("%s_no_done_after_abort", nm), 32'(quiet), 32'd1);
        return;
      end
      chk($sformatf("%s_busy_c%0d", nm, k), 32'(busy), 32'(k < 32));
      chk($sformatf("%s_done_c%0d", nm, k), 32'(done), 32'(k == 32));
      if (k < 32) begin
        chk($sformatf("%s_hi_hold_c%0d", nm, k), HI, m_hi);
        chk($sformatf("%s_lo_hold_c%0d", nm, k), LO, m_lo);
      end else begin
        chk($sformatf("%s_hi_c%0d", nm, k), HI, eh);
        chk($sformatf("%s_lo_c%0d", nm, k), LO, el);
      end
      if (mode == 1) begin
        case (k)
          5: begin start = 1'b1; op = 2'b01; BusA = 32'd5; BusB = 32'd5; end
          6: begin start = 1'b0; mthi = 1'b1; BusA = 32'h1234; end
          7: begin mthi = 1'b0; mtlo = 1'b1; BusA = 32'hDEAD_BEEF; BusB = 32'h0000_0001; end
          8: begin mtlo = 1'b0; end
          default: ;
        endcase
      end
      if (mode == 2 && k == 10) reset = 1'b1;
    end
    m_hi = eh; m_lo = el;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; BusA = 32'hFFFF_FFFF; BusB = 32'hFFFF_FFFF;
    mthi = 1'b1; mtlo = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset = 1'b0; mthi = 1'b0; mtlo = 1'b0;

    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; BusA = 32'hA5A5_0F0F;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthi_mtlo_hi", HI, 32'hA5A5_0F0F);
    chk("mthi_mtlo_lo", LO, 32'hA5A5_0F0F);
    mthi = 1'b1; BusA = 32'h0000_1111;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi_only_hi", HI, 32'h0000_1111);
    chk("mthi_only_lo", LO, 32'hA5A5_0F0F);
    m_hi = 32'h0000_1111; m_lo = 32'hA5A5_0F0F;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 3);
    run_op("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    run_op("mult_maxpos", 2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 0);
    run_op("div_m7by2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("div_7bym2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
    run_op("divu_by0", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 0);
    run_op("div_by0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);
    run_op("divu_big", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 0);
    run_op("divu_disturb", 2'b11, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 1);
    run_op("multu_abort", 2'b01, 32'h1234_5678, 32'd9, 32'd0, 32'd0, 2);

    @(negedge clk);
    mtlo = 1'b1; BusA = 32'h0000_CAFE;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo_cafe_lo", LO, 32'h0000_CAFE);
    chk("mtlo_cafe_hi", HI, 32'h0000_0000);
    m_lo = 32'h0000_CAFE;

    run_op("mult_m1xm1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
